// File: rtl/nios2_system_led_pio.sv
// rtl/nios2_system_led_pio.sv - Avalon-MM LED output PIO with atomic set/clear and blink engine
module nios2_system_led_pio #(
   parameter int                WIDTH       = 8,
   parameter int                PERIOD_W    = 24,
   parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic [WIDTH-1:0]  out_port
);

   logic [WIDTH-1:0]    data_q, data_d;
   logic [WIDTH-1:0]    mask_q, mask_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic [PERIOD_W-1:0] cnt_q, cnt_d;
   logic                phase_q, phase_d;
   logic [31:0]         readdata_q, readdata_d;
   logic                wr;
   logic                unused_wd;

   assign wr        = chipselect & ~write_n;
   assign unused_wd = ^writedata;

   always_comb begin
      data_d     = data_q;
      mask_d     = mask_q;
      period_d   = period_q;
      cnt_d      = cnt_q;
      phase_d    = phase_q;
      readdata_d = '0;

      if (period_q == '0) begin
         cnt_d   = '0;
         phase_d = 1'b0;
      end else if (cnt_q == period_q - PERIOD_W'(1)) begin
         cnt_d   = '0;
         phase_d = ~phase_q;
      end else begin
         cnt_d = cnt_q + PERIOD_W'(1);
      end

      // A period write restarts the blink cycle and overrides any toggle due this edge.
      if (wr) begin
         case (address)
            2'd0: data_d = writedata[WIDTH-1:0];
            2'd1: mask_d = writedata[WIDTH-1:0];
            2'd2: begin
               period_d = writedata[PERIOD_W-1:0];
               cnt_d    = '0;
               phase_d  = 1'b0;
            end
            default: data_d = (data_q | writedata[WIDTH-1:0]) & ~writedata[WIDTH+15:16];
         endcase
      end

      case (address)
         2'd0:    readdata_d = 32'(data_q);
         2'd1:    readdata_d = 32'(mask_q);
         2'd2:    readdata_d = 32'(period_q);
         default: readdata_d = {31'b0, phase_q};
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         data_q     <= RESET_VALUE;
         mask_q     <= '0;
         period_q   <= '0;
         cnt_q      <= '0;
         phase_q    <= 1'b0;
         readdata_q <= '0;
      end else begin
         data_q     <= data_d;
         mask_q     <= mask_d;
         period_q   <= period_d;
         cnt_q      <= cnt_d;
         phase_q    <= phase_d;
         readdata_q <= readdata_d;
      end
   end

   assign readdata = readdata_q;
   assign out_port = data_q ^ (mask_q & {WIDTH{phase_q}});

endmodule

// File: tb/tb_nios2_system_led_pio.sv
// tb/tb_nios2_system_led_pio.sv - scoreboard bench for the LED output PIO
module tb_nios2_system_led_pio;

   localparam logic [7:0] RV = 8'h5A;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [7:0]  out_port;

   int checks = 0;
   int errors = 0;

   logic [39:0] sb_q[$];

   logic [7:0]  m_data, m_mask;
   logic [23:0] m_period, m_cnt;
   logic        m_phase;

   nios2_system_led_pio #(.WIDTH(8), .PERIOD_W(24), .RESET_VALUE(RV)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .out_port   (out_port)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic cyc(input logic [1:0] a, input logic cs, input logic wn,
                      input logic [31:0] wd, input logic rn);
      logic [7:0]  nd, nm, eo;
      logic [23:0] np, nc;
      logic        nph;
      logic [31:0] nrd;
      logic [39:0] e;
      address = a; chipselect = cs; write_n = wn; writedata = wd; reset_n = rn;
      nd = m_data; nm = m_mask; np = m_period;
      case (a)
         2'd0: nrd = {24'b0, m_data};
         2'd1: nrd = {24'b0, m_mask};
         2'd2: nrd = {8'b0, m_period};
         default: nrd = {31'b0, m_phase};
      endcase
      if (m_period == 24'd0) begin nc = 0; nph = 0; end
      else if (m_cnt + 24'd1 == m_period) begin nc = 0; nph = ~m_phase; end
      else begin nc = m_cnt + 24'd1; nph = m_phase; end
      if (cs && !wn) begin
         if (a == 2'd0) nd = wd[7:0];
         if (a == 2'd1) nm = wd[7:0];
         if (a == 2'd2) begin np = wd[23:0]; nc = 0; nph = 0; end
         if (a == 2'd3) nd = (m_data | wd[7:0]) & ~wd[23:16];
      end
      if (!rn) begin
         nd = RV; nm = 0; np = 0; nc = 0; nph = 0; nrd = 0;
      end
      m_data = nd; m_mask = nm; m_period = np; m_cnt = nc; m_phase = nph;
      eo = nd ^ (nm & {8{nph}});
      sb_q.push_back({eo, nrd});
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check("sb_out", {24'b0, out_port}, {24'b0, e[39:32]});
      check("sb_rd", readdata, e[31:0]);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      cyc(a, 1'b1, 1'b0, d, 1'b1);
   endtask

   task automatic idle(input logic [1:0] a);
      cyc(a, 1'b0, 1'b1, 32'h0, 1'b1);
   endtask

   initial begin
      m_data = RV; m_mask = 0; m_period = 0; m_cnt = 0; m_phase = 0;
      cyc(2'd0, 1'b0, 1'b1, 32'h0, 1'b0);
      cyc(2'd0, 1'b0, 1'b1, 32'h0, 1'b0);
      check("rst_rd", readdata, 32'h0);
      check("rst_out", {24'b0, out_port}, {24'b0, RV});

      // basic write and registered read (old value on same-cycle write)
      wr(2'd0, 32'hA5);
      check("wr_out", {24'b0, out_port}, 32'hA5);
      check("rd_old", readdata, {24'b0, RV});
      idle(2'd0);
      check("rd_a5", readdata, 32'hA5);

      // set/clear with clear priority, upper bits dropped
      wr(2'd0, 32'hF0);
      wr(2'd3, 32'h00FF0003);
      check("sc_clr", {24'b0, out_port}, 32'h00);
      wr(2'd3, 32'h0000000F);
      check("sc_set", {24'b0, out_port}, 32'h0F);
      wr(2'd0, 32'h1FF);
      check("wr_trunc", {24'b0, out_port}, 32'hFF);

      // blink with period 4
      wr(2'd0, 32'h0);
      wr(2'd1, 32'h81);
      wr(2'd2, 32'h4);
      for (int i = 0; i < 3; i++) begin
         idle(2'd3);
         check("blink_pre", {24'b0, out_port}, 32'h00);
      end
      idle(2'd3);
      check("blink_t1", {24'b0, out_port}, 32'h81);
      for (int i = 0; i < 3; i++) idle(2'd3);
      check("blink_ph", readdata, 32'h1);
      idle(2'd3);
      check("blink_t2", {24'b0, out_port}, 32'h00);
      for (int i = 0; i < 4; i++) idle(2'd3);
      check("blink_t3", {24'b0, out_port}, 32'h81);

      // mid-blink period rewrite (phase=1, cnt=2)
      idle(2'd2);
      idle(2'd2);
      wr(2'd2, 32'd10);
      check("rew_out", {24'b0, out_port}, 32'h00);
      for (int i = 0; i < 9; i++) idle(2'd3);
      check("rew_pre", {24'b0, out_port}, 32'h00);
      idle(2'd3);
      check("rew_t", {24'b0, out_port}, 32'h81);
      wr(2'd2, 32'd0);
      for (int i = 0; i < 6; i++) idle(2'd3);
      check("dis_out", {24'b0, out_port}, 32'h00);
      check("dis_ph", readdata, 32'h0);

      // reset mid-blink with a pending write
      wr(2'd2, 32'd3);
      for (int i = 0; i < 3; i++) idle(2'd0);
      check("pre_rst", {24'b0, out_port}, 32'h81);
      cyc(2'd0, 1'b1, 1'b0, 32'h33, 1'b0);
      check("rst2_out", {24'b0, out_port}, {24'b0, RV});
      check("rst2_rd", readdata, 32'h0);
      idle(2'd1);
      check("rst2_mask", readdata, 32'h0);
      idle(2'd2);
      check("rst2_per", readdata, 32'h0);
      for (int i = 0; i < 5; i++) idle(2'd0);
      check("rst2_data", readdata, {24'b0, RV});
      check("rst2_hold", {24'b0, out_port}, {24'b0, RV});

      // set/clear coinciding with a phase toggle
      wr(2'd0, 32'h0);
      wr(2'd1, 32'h1);
      wr(2'd2, 32'h4);
      for (int i = 0; i < 3; i++) idle(2'd0);
      wr(2'd3, 32'h00000001);
      check("coin_out", {24'b0, out_port}, 32'h00);
      idle(2'd0);
      check("coin_data", readdata, 32'h1);
      idle(2'd3);
      check("coin_ph", readdata, 32'h1);

      // random traffic against the scoreboard model
      for (int i = 0; i < 300; i++) begin
         logic [1:0]  ra;
         logic [31:0] rd;
         ra = 2'($urandom_range(0, 3));
         rd = $urandom;
         if (ra == 2'd2) rd = 32'($urandom_range(0, 6)) | (rd & 32'hFF000000);
         if ($urandom_range(0, 99) < 2) cyc(ra, 1'b1, 1'b0, rd, 1'b0);
         else if ($urandom_range(0, 3) == 0) cyc(ra, 1'b1, 1'b0, rd, 1'b1);
         else cyc(ra, 1'($urandom_range(0, 1)), 1'b1, rd, 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
